// File: rtl/and_gate_pkg.sv
// Shared definitions for the and_gate block.
//   AND_DEFAULT_WIDTH : default operand width
//   AND_DEFAULT_CNT_W : default width of the output-high cycle counter
//   sat_inc()         : increment that holds at a supplied maximum
package and_gate_pkg;

  localparam int AND_DEFAULT_WIDTH = 1;
  localparam int AND_DEFAULT_CNT_W = 8;

  // Operands are carried at 32 bits so one function serves every counter
  // width up to 32; callers narrow the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [31:0] max);
    return (cnt == max) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/and_gate_if.sv
// Signal bundle for the and_gate block.
//   a, b    : operands (driven by master)
//   y       : combinational a & b
//   y_q     : registered a & b
//   y_all_q : registered "all bits of a & b high"
//   hi_cnt  : saturating count of cycles with a & b nonzero
// Modports: master drives operands and observes results; slave is the gate.
interface and_gate_if
  import and_gate_pkg::*;
#(
  parameter int WIDTH = AND_DEFAULT_WIDTH,
  parameter int CNT_W = AND_DEFAULT_CNT_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_all_q;
  logic [CNT_W-1:0] hi_cnt;

  modport master (output a, b, input y, y_q, y_all_q, hi_cnt);
  modport slave  (input a, b, output y, y_q, y_all_q, hi_cnt);

endinterface

// File: rtl/and_gate_sat_cnt.sv
// Saturating up-counter.
//   clk : rising-edge clock
//   rst : synchronous active-high clear, wins over inc
//   inc : count this cycle
//   cnt : current count; holds at all-ones, never wraps
module and_gate_sat_cnt
  import and_gate_pkg::*;
#(
  parameter int CNT_W = AND_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_p1;

  // Stage p1: counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (inc) begin
      cnt_p1 <= CNT_W'(sat_inc(32'(cnt_p1), 32'(CNT_MAX)));
    end
  end

  assign cnt = cnt_p1;

endmodule

// File: rtl/and_gate.sv
// Bitwise 2-input AND with optional registered outputs.
//   clk : rising-edge clock, used only by the registered outputs
//   rst : synchronous active-high reset of the registered outputs
//   bus : and_gate_if slave -- a, b in; y (combinational), y_q, y_all_q,
//         hi_cnt (registered, one cycle latency) out
// y never depends on clk or rst. With REG_OUT = 0 the registered outputs
// are tied to zero.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH   = AND_DEFAULT_WIDTH,
  parameter int CNT_W   = AND_DEFAULT_CNT_W,
  parameter bit REG_OUT = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  and_gate_if.slave bus
);

  // Stage p0: combinational AND
  logic [WIDTH-1:0] y_p0;

  assign y_p0  = bus.a & bus.b;
  assign bus.y = y_p0;

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] y_p1;
      logic             y_all_p1;
      logic [CNT_W-1:0] hi_cnt_p1;

      // Stage p1: registered result and all-high flag
      always_ff @(posedge clk) begin
        if (rst) begin
          y_p1     <= '0;
          y_all_p1 <= 1'b0;
        end else begin
          y_p1     <= y_p0;
          y_all_p1 <= &y_p0;
        end
      end

      and_gate_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
        .clk (clk),
        .rst (rst),
        .inc (|y_p0),
        .cnt (hi_cnt_p1)
      );

      assign bus.y_q     = y_p1;
      assign bus.y_all_q = y_all_p1;
      assign bus.hi_cnt  = hi_cnt_p1;
    end else begin : g_noreg
      assign bus.y_q     = '0;
      assign bus.y_all_q = 1'b0;
      assign bus.hi_cnt  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_and_gate.sv
// Directed testbench for and_gate: three instances (WIDTH=1/CNT_W=8,
// WIDTH=4/CNT_W=8, WIDTH=1/CNT_W=2) sharing clk and rst.
module tb_and_gate;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  and_gate_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  and_gate_if #(.WIDTH(4), .CNT_W(8)) if4 ();
  and_gate_if #(.WIDTH(1), .CNT_W(2)) ifs ();

  and_gate #(.WIDTH(1), .CNT_W(8), .REG_OUT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  and_gate #(.WIDTH(4), .CNT_W(8), .REG_OUT(1'b1)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  and_gate #(.WIDTH(1), .CNT_W(2), .REG_OUT(1'b1)) duts (.clk(clk), .rst(rst), .bus(ifs));

  // One full clock: rising edge, then falling edge; outputs are sampled
  // after the falling edge, well away from the rising edge.
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_sat [5];

  initial begin
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    if1.a = 1'b0; if1.b = 1'b0;
    if4.a = 4'b0; if4.b = 4'b0;
    ifs.a = 1'b0; ifs.b = 1'b0;

    // Truth table with clk idle
    if1.a = 1'b0; if1.b = 1'b0; #10 check("tt_00", 32'(if1.y), 32'd0);
    if1.a = 1'b0; if1.b = 1'b1; #10 check("tt_01", 32'(if1.y), 32'd0);
    if1.a = 1'b1; if1.b = 1'b0; #10 check("tt_10", 32'(if1.y), 32'd0);
    if1.a = 1'b1; if1.b = 1'b1; #10 check("tt_11", 32'(if1.y), 32'd1);

    // X handling: 0 forces 0, 1 passes X through
    if1.a = 1'b0; if1.b = 1'bx; #10 check("x_0x", 32'(if1.y), 32'd0);
    if1.a = 1'b1; if1.b = 1'bx; #10 check("x_1x", 32'(if1.y), {31'd0, 1'bx});

    // Wide combinational AND
    if4.a = 4'b1100; if4.b = 4'b1010; #10 check("w4_y", 32'(if4.y), 32'h8);

    // Combinational path ignores reset; reset clears registers
    rst = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
    #1 check("rst_y_comb", 32'(if1.y), 32'd1);
    tick();
    check("rst_y_q",     32'(if1.y_q),     32'd0);
    check("rst_y_all_q", 32'(if1.y_all_q), 32'd0);
    check("rst_hi_cnt",  32'(if1.hi_cnt),  32'd0);
    check("rst_w4_cnt",  32'(if4.hi_cnt),  32'd0);

    // Register latency
    rst = 1'b0;
    tick();
    check("lat_y_q",     32'(if1.y_q),     32'd1);
    check("lat_y_all_q", 32'(if1.y_all_q), 32'd1);
    check("lat_hi_cnt",  32'(if1.hi_cnt),  32'd1);
    check("w4_y_q",      32'(if4.y_q),     32'h8);
    check("w4_y_all_q",  32'(if4.y_all_q), 32'd0);
    check("w4_hi_cnt1",  32'(if4.hi_cnt),  32'd1);
    if1.a = 1'b0;
    #1 check("lat_y_drop", 32'(if1.y), 32'd0);
    check("lat_y_q_hold", 32'(if1.y_q), 32'd1);
    tick();
    check("lat_y_q_clr",  32'(if1.y_q),    32'd0);
    check("lat_cnt_hold", 32'(if1.hi_cnt), 32'd1);
    check("w4_hi_cnt2",   32'(if4.hi_cnt), 32'd2);

    // All bits high on the wide instance
    if4.a = 4'b1111; if4.b = 4'b1111;
    tick();
    check("w4_all_y_q",  32'(if4.y_q),     32'hF);
    check("w4_all_flag", 32'(if4.y_all_q), 32'd1);
    check("w4_hi_cnt3",  32'(if4.hi_cnt),  32'd3);

    // Saturation on the 2-bit counter
    ifs.a = 1'b1; ifs.b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_%0d", i), 32'(ifs.hi_cnt), 32'(exp_sat[i]));
    end
    rst = 1'b1;
    tick();
    check("sat_rst", 32'(ifs.hi_cnt), 32'd0);

    // Reset priority over an increment
    if1.a = 1'b1; if1.b = 1'b1;
    tick();
    check("prio_cnt", 32'(if1.hi_cnt), 32'd0);
    check("prio_y_q", 32'(if1.y_q),    32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_cnt", 32'(if1.hi_cnt), 32'd1);
    check("post_rst_y_q", 32'(if1.y_q),    32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
